// File: rtl/receive.sv
// Receiver for the 10-bit parity-protected count link.
// It checks even parity and acquires the 9-bit count sequence (HUNT -> SYNC -> LOCKED).
// It tracks the sequence and issues valid / parity_err / seq_err pulses.
// It also keeps saturating error tallies.
module receive #(
  parameter int LOCK_COUNT  = 3,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic [9:0]       data_in,
  output logic [8:0]       data_out,
  output logic             valid,
  output logic             parity_err,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] parity_errs,
  output logic [ERR_W-1:0] seq_errs
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t        r_state, w_state;
  logic [8:0]    r_ref, w_ref;
  logic [GW-1:0] r_good_cnt, w_gc;
  logic [MW-1:0] r_miss_cnt, w_mc;
  logic [8:0]    w_dout;
  logic          w_valid, w_perr, w_serr;

  logic [8:0] w_pl;
  logic       w_good, w_adv, w_hold;

  assign w_pl   = data_in[8:0];
  assign w_good = ~(^data_in);
  assign w_adv  = (w_pl == r_ref + 9'd1);  // 9-bit add wraps 511 -> 0
  assign w_hold = (w_pl == r_ref);
  assign locked = (r_state == LOCKED);

  // Next-state and next-output decode for the sampled word
  always_comb begin
    w_state = r_state;
    w_ref   = r_ref;
    w_gc    = r_good_cnt;
    w_mc    = r_miss_cnt;
    w_dout  = data_out;
    w_valid = 1'b0;
    w_perr  = 1'b0;
    w_serr  = 1'b0;
    if (enable) begin
      case (r_state)
        HUNT: begin
          if (w_good) begin
            w_ref   = w_pl;
            w_gc    = '0;
            w_state = SYNC;
          end else begin
            w_perr = 1'b1;
          end
        end
        SYNC: begin
          if (!w_good) begin
            w_perr  = 1'b1;
            w_state = HUNT;
          end else if (w_adv) begin
            w_ref = w_pl;
            w_gc  = r_good_cnt + 1'b1;
            if (w_gc == GW'(LOCK_COUNT)) begin
              w_state = LOCKED;
              w_dout  = w_pl;
              w_valid = 1'b1;
              w_mc    = '0;
            end
          end else if (!w_hold) begin
            // restart acquisition on the new count, silently
            w_ref = w_pl;
            w_gc  = '0;
          end
        end
        LOCKED: begin
          if (w_good && w_adv) begin
            w_ref   = w_pl;
            w_dout  = w_pl;
            w_valid = 1'b1;
            w_mc    = '0;
          end else if (w_good && w_hold) begin
            w_mc = '0;  // paused transmitter is not a fault
          end else begin
            if (w_good) begin
              w_serr = 1'b1;
              w_ref  = w_pl;  // resync so a transmitter restart costs one error
            end else begin
              w_perr = 1'b1;
            end
            w_mc = r_miss_cnt + 1'b1;
            if (w_mc == MW'(LOSS_THRESH)) begin
              w_state = HUNT;
              w_gc    = '0;
            end
          end
        end
        default: w_state = HUNT;
      endcase
    end
  end

  // State, payload, pulse and counter registers
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state     <= HUNT;
      r_ref       <= '0;
      r_good_cnt  <= '0;
      r_miss_cnt  <= '0;
      data_out    <= '0;
      valid       <= 1'b0;
      parity_err  <= 1'b0;
      seq_err     <= 1'b0;
      parity_errs <= '0;
      seq_errs    <= '0;
    end else begin
      r_state    <= w_state;
      r_ref      <= w_ref;
      r_good_cnt <= w_gc;
      r_miss_cnt <= w_mc;
      data_out   <= w_dout;
      valid      <= w_valid;
      parity_err <= w_perr;
      seq_err    <= w_serr;
      if (w_perr && parity_errs != '1) parity_errs <= parity_errs + 1'b1;
      if (w_serr && seq_errs != '1)    seq_errs    <= seq_errs + 1'b1;
    end
  end
endmodule

// File: tb/tb_receive.sv
// Directed bench for receive.
// A behavioural model is compared against the DUT on every falling edge.
// Literal checks pin the model at the key points of each scenario.
module tb_receive;
  localparam int EW  = 6;  // narrow counters so saturation is reachable
  localparam int MAX = (1 << EW) - 1;

  logic          clk, clear, enable;
  logic [9:0]    data_in;
  logic [8:0]    data_out;
  logic          valid, parity_err, seq_err, locked;
  logic [EW-1:0] parity_errs, seq_errs;

  receive #(.LOCK_COUNT(3), .LOSS_THRESH(4), .ERR_W(EW)) dut (
    .clk(clk), .clear(clear), .enable(enable), .data_in(data_in),
    .data_out(data_out), .valid(valid), .parity_err(parity_err),
    .seq_err(seq_err), .locked(locked), .parity_errs(parity_errs),
    .seq_errs(seq_errs)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit run   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] gw(input int c);
    logic [8:0] p;
    p = c[8:0];
    return {^p, p};
  endfunction

  function automatic logic [9:0] bw(input int c);
    logic [8:0] p;
    p = c[8:0];
    return {~(^p), p};
  endfunction

  // ---------------- behavioural model ----------------
  int m_mode;  // 0 hunting, 1 syncing, 2 locked
  int m_ref, m_good, m_miss, m_dout, m_pe, m_se;
  bit m_v, m_p, m_q;

  // Advance the model on every word the receiver would sample
  always @(posedge clk or posedge clear) begin : model
    int s, r, g, m, d, pe, se, pl;
    bit v, p, q, good;
    s = m_mode; r = m_ref; g = m_good; m = m_miss; d = m_dout; pe = m_pe; se = m_se;
    v = 0; p = 0; q = 0;
    if (clear) begin
      s = 0; r = 0; g = 0; m = 0; d = 0; pe = 0; se = 0;
    end else if (enable) begin
      good = ((^data_in) == 1'b0);
      pl   = int'(data_in[8:0]);
      if (s == 0) begin
        if (good) begin r = pl; g = 0; s = 1; end
        else p = 1;
      end else if (s == 1) begin
        if (!good) begin p = 1; s = 0; end
        else if (pl == (r + 1) % 512) begin
          r = pl; g = g + 1;
          if (g == 3) begin s = 2; d = pl; v = 1; m = 0; end
        end else if (pl != r) begin r = pl; g = 0; end
      end else begin
        if (good && pl == (r + 1) % 512) begin r = pl; d = pl; v = 1; m = 0; end
        else if (good && pl == r) m = 0;
        else begin
          if (good) begin q = 1; r = pl; end else p = 1;
          m = m + 1;
          if (m == 4) begin s = 0; g = 0; end
        end
      end
      if (p && pe < MAX) pe = pe + 1;
      if (q && se < MAX) se = se + 1;
    end
    m_mode <= s; m_ref <= r; m_good <= g; m_miss <= m; m_dout <= d;
    m_pe <= pe; m_se <= se; m_v <= v; m_p <= p; m_q <= q;
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (run) begin
      chk("m.data_out",    data_out,    m_dout);
      chk("m.valid",       valid,       m_v);
      chk("m.parity_err",  parity_err,  m_p);
      chk("m.seq_err",     seq_err,     m_q);
      chk("m.locked",      locked,      m_mode == 2);
      chk("m.parity_errs", parity_errs, m_pe);
      chk("m.seq_errs",    seq_errs,    m_se);
    end
  end

  task automatic send(input logic [9:0] w);
    enable = 1'b1; data_in = w;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    enable = 1'b0; data_in = 10'h3FF;
    @(posedge clk); #1;
  endtask

  initial begin
    clear = 1'b0; enable = 1'b0; data_in = '0;
    #2 clear = 1'b1;
    #10 clear = 1'b0;
    @(posedge clk); #1;
    chk("rst.data_out", data_out, 0);
    chk("rst.locked", locked, 0);
    chk("rst.valid", valid, 0);
    chk("rst.errs", {parity_errs, seq_errs}, 0);
    run = 1;

    // acquisition and first valid words
    send(gw(0)); send(gw(1)); send(gw(2));
    chk("acq.not_locked", locked, 0);
    chk("acq.no_valid", valid, 0);
    send(gw(3));
    chk("acq.locked", locked, 1);
    chk("acq.valid3", valid, 1);
    chk("acq.dout3", data_out, 3);
    send(gw(4));
    chk("acq.dout4", data_out, 4);
    chk("acq.errs", {parity_errs, seq_errs}, 0);

    // parity fault at 11, then 12 is out of sequence
    for (int c = 5; c <= 10; c++) send(gw(c));
    send(10'h00B);
    chk("par.pulse", parity_err, 1);
    chk("par.no_valid", valid, 0);
    chk("par.count", parity_errs, 1);
    chk("par.dout", data_out, 10);
    send(gw(12));
    chk("par.seq_pulse", seq_err, 1);
    chk("par.seq_count", seq_errs, 1);
    chk("par.locked", locked, 1);

    // wrap and pause
    send(gw(13)); send(gw(509));
    send(gw(510)); chk("wrap.510", data_out, 510);
    send(gw(511)); chk("wrap.511", data_out, 511);
    send(gw(511)); chk("wrap.hold_novalid", valid, 0);
    send(gw(511)); chk("wrap.hold_noerr", seq_err, 0);
    send(gw(0));   chk("wrap.0v", valid, 1); chk("wrap.0", data_out, 0);
    send(gw(1));   chk("wrap.1", data_out, 1);
    chk("wrap.seq_errs", seq_errs, 2);

    // transmitter clear
    send(gw(200));
    send(gw(0)); chk("txclr.seq", seq_err, 1); chk("txclr.locked", locked, 1);
    send(gw(1)); chk("txclr.1", data_out, 1); chk("txclr.v1", valid, 1);
    send(gw(2)); chk("txclr.2", data_out, 2);
    chk("txclr.seq_errs", seq_errs, 4);

    // loss of lock on four bad words
    send(bw(3)); send(bw(4)); send(bw(5));
    chk("loss.still_locked", locked, 1);
    send(bw(6));
    chk("loss.dropped", locked, 0);
    chk("loss.perrs", parity_errs, 5);
    send(gw(50)); chk("loss.sync", locked, 0);
    send(gw(51)); send(gw(52)); send(gw(53));
    chk("relock", locked, 1); chk("relock.dout", data_out, 53);

    // enable gating
    repeat (3) idle();
    chk("gate.valid", valid, 0);
    chk("gate.perr", parity_err, 0);
    chk("gate.dout", data_out, 53);
    send(gw(54)); chk("gate.resume", data_out, 54);

    // seq_err saturation
    for (int i = 0; i < 70; i++) begin send(gw(100)); send(gw(101)); end
    chk("sat.seq", seq_errs, MAX);
    chk("sat.locked", locked, 1);

    // parity_err saturation
    for (int i = 0; i < 70; i++) send(bw(i));
    chk("sat.par", parity_errs, MAX);
    chk("sat.hunt", locked, 0);

    // relock, then async clear between edges
    for (int c = 20; c <= 23; c++) send(gw(c));
    chk("pre_clr.locked", locked, 1);
    #3 clear = 1'b1;
    #1;
    chk("aclr.dout", data_out, 0);
    chk("aclr.locked", locked, 0);
    chk("aclr.errs", {parity_errs, seq_errs}, 0);
    #1 clear = 1'b0;
    @(posedge clk); #1;
    send(gw(7));
    chk("post_clr.locked", locked, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/receive.md
Name: receive

Overview:
- Receiving end of the 10-bit parity-protected count link.
- Accepts one 10-bit word per clock: bit 9 is the even-parity bit, bits 8:0 are the 9-bit sequence count.
- Checks parity, acquires and tracks the count sequence (hold or +1 mod 512), and flags parity and sequence errors.
- Keeps saturating error tallies and delivers verified payloads to downstream logic.

Parameters:
- LOCK_COUNT, 3: consecutive good +1 advances required in SYNC before declaring lock.
- LOSS_THRESH, 4: consecutive bad words in LOCKED that drop the block back to HUNT.
- ERR_W, 16: width of each saturating error counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clear  input  1  reset, asynchronous, active-high.
- enable  input  1  sample data_in this cycle; when low, state is held and no pulses are issued.
- data_in  input  10  received word: {parity, count[8:0]}.
- data_out  output  9  last accepted payload, registered.
- valid  output  1  one-cycle pulse: data_out was updated with a new, in-sequence payload.
- parity_err  output  1  one-cycle pulse: the sampled word failed the parity check.
- seq_err  output  1  one-cycle pulse: in LOCKED, the word had good parity but was out of sequence.
- locked  output  1  high while in state LOCKED.
- parity_errs  output  ERR_W  saturating count of parity_err pulses.
- seq_errs  output  ERR_W  saturating count of seq_err pulses.

Behaviour:
- Reset: clear high asynchronously forces the following, regardless of clk or enable:
  - state HUNT; ref=0, good_cnt=0, miss_cnt=0;
  - data_out=0, valid=0, parity_err=0, seq_err=0, locked=0, parity_errs=0, seq_errs=0.
- Parity: a word is good when the XOR of all 10 bits is 0. payload = data_in[8:0].
- Latency: data_in is sampled at edge N when enable=1; all outputs reflect that word after edge N (one cycle).
- Pulse outputs are 0 in every cycle not explicitly pulsed, and whenever enable=0.
- Advance means payload == (ref+1) mod 512, so 511 -> 0 is an advance. Hold means payload == ref.
- HUNT:
  - good word: ref<=payload, good_cnt<=0, go to SYNC.
  - bad parity: parity_err pulse, stay in HUNT.
- SYNC:
  - good advance: ref<=payload, good_cnt++.
  - If good_cnt reaches LOCK_COUNT: go to LOCKED, data_out<=payload, valid pulse, miss_cnt<=0.
  - good hold: no change.
  - good word that is neither hold nor advance: ref<=payload, good_cnt<=0, stay in SYNC, no seq_err.
  - bad parity: parity_err pulse, go to HUNT.
- LOCKED (locked=1):
  - good advance: ref<=payload, data_out<=payload, valid pulse, miss_cnt<=0.
  - good hold: no pulse, miss_cnt<=0. This covers a paused transmitter.
  - good mismatch: seq_err pulse, ref<=payload so a transmitter clear costs exactly one error, miss_cnt++.
  - bad parity: parity_err pulse, ref unchanged, miss_cnt++.
  - When miss_cnt would reach LOSS_THRESH: go to HUNT, locked=0 on the next cycle, good_cnt<=0.
- Error counters: increment on the same edge as the matching pulse; hold at 2^ERR_W-1 with no wrap.
- Both counters are cleared only by clear.
- data_out holds its last value across HUNT and SYNC; it updates only together with valid.

Test Plan:
- Reset and stream: clear pulse, then enable=1 with counts 0,1,2,3,4 at correct parity.
  - Required: locked rises after the word 3 edge; valid pulses with data_out=3, then 4; both error counters stay 0.
- Parity fault: while locked at count 10, send count 11 with bit 9 inverted (10'h00B), then 12.
  - Required: parity_err pulses once and parity_errs=1; valid does not fire for 11.
  - Count 12 is then seen as ref(10)+2, so seq_err pulses and seq_errs=1.
  - locked stays 1, because miss_cnt=2 < 4.
- Wrap and pause: locked, send 510, 511, 511, 511, 0, 1.
  - Required: valid pulses with data_out=510, 511, 0, 1; no pulse on the repeated 511s; no errors.
- Transmitter clear: locked at 200, then 0,1,2.
  - Required: one seq_err on 0, then valid with 1 and 2; locked never drops.
- Loss of lock: locked, then 4 consecutive bad-parity words.
  - Required: 4 parity_err pulses; locked falls after the 4th; the next good word moves the block to SYNC.
- Enable gating and async reset:
  - enable=0 with garbage on data_in gives no pulses and no state change.
  - Asserting clear mid-cycle zeroes every output immediately, before the next clk edge.
